// File: rtl/mii_gen_pkg.sv
// Shared definitions for the MII transmit frame generator: control codes, FSM states, lane mask helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mii_gen_pkg;

    // XGMII-style control characters.
    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_ERR   = 8'hFE;

    // Widest supported bus (64 bits) carries eight byte lanes.
    localparam int MAX_LANES = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TERM = 2'd2
    } state_t;

    // Returns a mask with the lowest n lanes set; these are the lanes that carry data in a tail word.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [3:0] n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (k < int'(n)) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mii_tail_builder.sv
// Builds the final data word of a frame: rem data lanes, /T/ at lane rem, /I/ fill above it.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when the word is used.
//
// Ports:
//   i_rem     number of data bytes left (1..LANES-1); lane 0 always holds the carried byte
//   i_carry   byte held over from the previous input word
//   i_data    low DATA_W-8 bits of the current input word (its top byte can never land in a tail)
//   o_tail_d  tail word data
//   o_tail_c  tail word per-lane control flags (1 = control character)
module mii_tail_builder
    import mii_gen_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [3:0]          i_rem,
    input  logic [7:0]          i_carry,
    input  logic [DATA_W-9:0]   i_data,
    output logic [DATA_W-1:0]   o_tail_d,
    output logic [DATA_W/8-1:0] o_tail_c
);

    localparam int LANES = DATA_W / 8;

    logic [MAX_LANES-1:0] data_mask;
    logic [DATA_W-1:0]    shifted;

    assign data_mask = lane_mask(i_rem);
    // Input bytes move up one lane because lane 0 is occupied by the carried byte.
    assign shifted   = {i_data, i_carry};

    always_comb begin
        o_tail_d = {LANES{MII_IDLE}};
        o_tail_c = '1;
        for (int k = 0; k < LANES; k++) begin
            if (data_mask[k]) begin
                o_tail_d[8*k +: 8] = shifted[8*k +: 8];
                o_tail_c[k]        = 1'b0;
            end else if (k == int'(i_rem)) begin
                o_tail_d[8*k +: 8] = MII_TERM;
            end
        end
    end

endmodule

// File: rtl/mii_frame_tx_gen.sv
// Turns a length-tagged payload stream into lane-aligned MII words: /S/ lane 0, payload, /T/, /I/ fill.
// Latency: one cycle; the word built from a cycle-N handshake is on o_mii_tx_d/o_mii_tx_c at N+1.
// Backpressure: o_ready gates payload; a missing word while o_ready=1 aborts the frame with an /E/ word.
//
// Ports:
//   clk, i_rst               clock, asynchronous active-high reset
//   i_start/i_frame_len      frame request and its payload length, taken when i_start && o_start_rdy
//   o_start_rdy              idle and inter-packet gap satisfied
//   i_valid/i_data/o_ready   payload word handshake, byte 0 in [7:0]
//   o_mii_tx_d/o_mii_tx_c    registered MII data and per-lane control flags
//   o_frame_done             pulse with the word carrying /T/
//   o_len_err                pulse when a requested length is out of range (frame dropped)
//   o_underrun               pulse with the all-/E/ word
// Build option MII_FRAME_TX_GEN_STATS_EN adds o_frame_cnt (frames finished) and o_err_cnt
// (length errors + underruns), both wrapping.
module mii_frame_tx_gen
    import mii_gen_pkg::*;
#(
    parameter int DATA_W          = 64,
    parameter int LEN_W           = 16,
    parameter int IPG_BYTES       = 12,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [LEN_W-1:0]    i_frame_len,
    output logic                o_start_rdy,
    input  logic                i_valid,
    input  logic [DATA_W-1:0]   i_data,
    output logic                o_ready,
    output logic [DATA_W-1:0]   o_mii_tx_d,
    output logic [DATA_W/8-1:0] o_mii_tx_c,
    output logic                o_frame_done,
    output logic                o_len_err,
    output logic                o_underrun
`ifdef MII_FRAME_TX_GEN_STATS_EN
    ,
    output logic [31:0]         o_frame_cnt,
    output logic [15:0]         o_err_cnt
`endif
);

    localparam int LANES = DATA_W / 8;
    // Counter must hold IPG_BYTES plus one word of headroom before saturation.
    localparam int IPG_W = $clog2(IPG_BYTES + LANES + 1);

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic                 first_q, first_d;
    logic [7:0]           carry_q, carry_d;
    logic [IPG_W-1:0]     ipg_cnt_q, ipg_cnt_d;
    logic [DATA_W-1:0]    tx_d_q, tx_d_d;
    logic [LANES-1:0]     tx_c_q, tx_c_d;
    logic                 frame_done_q, frame_done_d;
    logic                 len_err_q, len_err_d;
    logic                 underrun_q, underrun_d;

    logic                 start_acc;
    logic                 len_bad;
    logic                 underrun;
    logic                 is_tail;
    logic [IPG_W-1:0]     ipg_sum;
    logic [IPG_W-1:0]     ipg_idle_next;
    logic [DATA_W-1:0]    data_word;
    logic [DATA_W-1:0]    tail_d;
    logic [LANES-1:0]     tail_c;

    assign o_start_rdy = (state_q == S_IDLE) && (ipg_cnt_q == IPG_W'(IPG_BYTES));
    // With a single byte left it is already in carry_q, so no input word is needed.
    assign o_ready     = (state_q == S_DATA) && (first_q || (rem_q >= LEN_W'(2)));

    assign start_acc = i_start && o_start_rdy;
    assign len_bad   = (i_frame_len < LEN_W'(MIN_FRAME_BYTES)) ||
                       (i_frame_len > LEN_W'(MAX_FRAME_BYTES));
    assign underrun  = (state_q == S_DATA) && o_ready && !i_valid;
    assign is_tail   = !first_q && (rem_q < LEN_W'(LANES));

    // Idle words add LANES bytes of gap; saturate once the minimum is met.
    assign ipg_sum       = ipg_cnt_q + IPG_W'(LANES);
    assign ipg_idle_next = (ipg_sum > IPG_W'(IPG_BYTES)) ? IPG_W'(IPG_BYTES) : ipg_sum;

    // Steady-state word: carried byte in lane 0, current input shifted up one lane.
    assign data_word = {i_data[DATA_W-9:0], carry_q};

    mii_tail_builder #(
        .DATA_W (DATA_W)
    ) u_tail (
        .i_rem    (rem_q[3:0]),
        .i_carry  (carry_q),
        .i_data   (i_data[DATA_W-9:0]),
        .o_tail_d (tail_d),
        .o_tail_c (tail_c)
    );

    // State register.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_acc && !len_bad) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (underrun) begin
                    state_d = S_IDLE;
                end else if (!first_q && (rem_q == LEN_W'(LANES))) begin
                    state_d = S_TERM;
                end else if (is_tail) begin
                    state_d = S_IDLE;
                end
            end
            S_TERM: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and output word construction.
    always_comb begin
        rem_d        = rem_q;
        first_d      = first_q;
        carry_d      = carry_q;
        ipg_cnt_d    = ipg_cnt_q;
        tx_d_d       = {LANES{MII_IDLE}};
        tx_c_d       = '1;
        frame_done_d = 1'b0;
        len_err_d    = 1'b0;
        underrun_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ipg_cnt_d = ipg_idle_next;
                if (start_acc) begin
                    if (len_bad) begin
                        len_err_d = 1'b1;
                    end else begin
                        rem_d   = i_frame_len;
                        first_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (underrun) begin
                    tx_d_d     = {LANES{MII_ERR}};
                    underrun_d = 1'b1;
                    ipg_cnt_d  = '0;
                    first_d    = 1'b0;
                end else if (first_q) begin
                    // /S/ displaces one payload byte; the top byte waits in carry.
                    tx_d_d  = {i_data[DATA_W-9:0], MII_START};
                    tx_c_d  = {{(LANES-1){1'b0}}, 1'b1};
                    carry_d = i_data[DATA_W-1 -: 8];
                    rem_d   = rem_q - LEN_W'(LANES - 1);
                    first_d = 1'b0;
                end else if (!is_tail) begin
                    // rem >= LANES: a full data word; at exactly LANES the /T/ goes in the next word.
                    tx_d_d  = data_word;
                    tx_c_d  = '0;
                    carry_d = i_data[DATA_W-1 -: 8];
                    rem_d   = rem_q - LEN_W'(LANES);
                end else begin
                    tx_d_d       = tail_d;
                    tx_c_d       = tail_c;
                    frame_done_d = 1'b1;
                    // /T/ and the /I/ above it already count toward the gap.
                    ipg_cnt_d    = IPG_W'(LANES) - IPG_W'(rem_q);
                end
            end
            S_TERM: begin
                tx_d_d       = {{(LANES-1){MII_IDLE}}, MII_TERM};
                frame_done_d = 1'b1;
                ipg_cnt_d    = IPG_W'(LANES);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rem_q        <= '0;
            first_q      <= 1'b0;
            carry_q      <= '0;
            ipg_cnt_q    <= '0;
            tx_d_q       <= {LANES{MII_IDLE}};
            tx_c_q       <= '1;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            rem_q        <= rem_d;
            first_q      <= first_d;
            carry_q      <= carry_d;
            ipg_cnt_q    <= ipg_cnt_d;
            tx_d_q       <= tx_d_d;
            tx_c_q       <= tx_c_d;
            frame_done_q <= frame_done_d;
            len_err_q    <= len_err_d;
            underrun_q   <= underrun_d;
        end
    end

    assign o_mii_tx_d   = tx_d_q;
    assign o_mii_tx_c   = tx_c_q;
    assign o_frame_done = frame_done_q;
    assign o_len_err    = len_err_q;
    assign o_underrun   = underrun_q;

`ifdef MII_FRAME_TX_GEN_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Counters advance with the registered pulses they count.
    always_comb begin
        frame_cnt_d = frame_cnt_q + {31'd0, frame_done_d};
        err_cnt_d   = err_cnt_q + {15'd0, (len_err_d | underrun_d)};
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_err_cnt   = err_cnt_q;
`endif

endmodule
